// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer: default channel count and filter length.
package sw_pkg;
  localparam int N_SW                = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 250000;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/sw_debounce_if.sv
// Switch bus between the raw switch source and the debouncer.
interface sw_debounce_if #(
  parameter int N_BITS = sw_pkg::N_SW
);
  logic [N_BITS-1:0] i_sw;
  logic [N_BITS-1:0] o_sw;
  logic [N_BITS-1:0] o_rise;
  logic [N_BITS-1:0] o_fall;

  modport master (output i_sw, input o_sw, o_rise, o_fall);
  modport slave  (input i_sw, output o_sw, o_rise, o_fall);
endinterface

// File: rtl/sw_debounce_bit.sv
// One debounced channel: 2-flop synchronizer, mismatch-run counter, level register
// and (with SW_DEBOUNCE_EDGE_EN) registered rise/fall pulses.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall
);
  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mismatch, accept;

  // Any return to the current level wipes the run; no partial credit survives.
  always_comb begin
    mismatch = sync2_q != lvl_q;
    accept   = mismatch && (cnt_q == LAST);
    lvl_d    = accept ? sync2_q : lvl_q;
    cnt_d    = (mismatch && !accept) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sw = lvl_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept &  sync2_q;
      fall_q <= accept & ~sync2_q;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif
endmodule

// File: rtl/sw_debounce.sv
// N-channel switch debouncer; edge pulse outputs are built only with SW_DEBOUNCE_EDGE_EN.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int N_BITS          = N_SW,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic         clock,
  input  logic         i_reset,
  sw_debounce_if.slave sw
);
  logic [N_BITS-1:0] sw_lvl, sw_rise, sw_fall;

  for (genvar g = 0; g < N_BITS; g++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock  (clock),
      .i_reset(i_reset),
      .i_sw   (sw.i_sw[g]),
      .o_sw   (sw_lvl[g]),
      .o_rise (sw_rise[g]),
      .o_fall (sw_fall[g])
    );
  end

  assign sw.o_sw   = sw_lvl;
  assign sw.o_rise = sw_rise;
  assign sw.o_fall = sw_fall;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, N_BITS=4; edge expectations
// follow SW_DEBOUNCE_EDGE_EN (zero when the macro is undefined).
module tb_sw_debounce;
  logic clock = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  sw_debounce_if #(.N_BITS(4)) bus ();

  sw_debounce #(
    .N_BITS(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .sw     (bus)
  );

  function automatic logic [3:0] ex(input logic [3:0] v);
`ifdef SW_DEBOUNCE_EDGE_EN
    return v;
`else
    return 4'h0 & v;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] s, input logic [3:0] r,
                         input logic [3:0] f);
    chk({tag, ".o_sw"},   bus.o_sw,   s);
    chk({tag, ".o_rise"}, bus.o_rise, r);
    chk({tag, ".o_fall"}, bus.o_fall, f);
  endtask

  // Input change was driven just before; the next edge samples it (k).
  // o_sw holds through k+4 and shows the new level after k+5, pulsing for one cycle.
  task automatic expect_accept(input string tag, input logic [3:0] old_sw,
                               input logic [3:0] new_sw, input logic [3:0] r,
                               input logic [3:0] f);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all($sformatf("%s.hold%0d", tag, i), old_sw, 4'h0, 4'h0);
    end
    step();
    chk_all({tag, ".accept"}, new_sw, ex(r), ex(f));
    step();
    chk_all({tag, ".after"}, new_sw, 4'h0, 4'h0);
  endtask

  initial begin
    // Reset with all switches high: everything stays 0.
    i_reset  = 1'b1;
    bus.i_sw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("reset%0d", i), 4'h0, 4'h0, 4'h0);
    end
    i_reset = 1'b0;
    expect_accept("rst_release", 4'h0, 4'hF, 4'hF, 4'h0);

    // All channels fall together.
    bus.i_sw = 4'h0;
    expect_accept("all_fall", 4'hF, 4'h0, 4'h0, 4'hF);

    // Three-cycle pulse on ch0 is rejected.
    bus.i_sw = 4'h1;
    for (int i = 0; i < 3; i++) step();
    bus.i_sw = 4'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("bounce3_%0d", i), 4'h0, 4'h0, 4'h0);
    end

    // ch1 clean rise then clean fall.
    bus.i_sw = 4'h2;
    expect_accept("ch1_rise", 4'h0, 4'h2, 4'h2, 4'h0);
    bus.i_sw = 4'h0;
    expect_accept("ch1_fall", 4'h2, 4'h0, 4'h0, 4'h2);

    // ch2 bounces 1,1,1,0 one sample short of acceptance, then holds 1.
    bus.i_sw = 4'h4; step();
    bus.i_sw = 4'h4; step();
    bus.i_sw = 4'h4; step();
    bus.i_sw = 4'h0; step();
    chk_all("ch2_bounce", 4'h0, 4'h0, 4'h0);
    bus.i_sw = 4'h4;
    expect_accept("ch2_rise", 4'h0, 4'h4, 4'h4, 4'h0);
    bus.i_sw = 4'h0;
    expect_accept("ch2_fall", 4'h4, 4'h0, 4'h0, 4'h4);

    // ch3: reset lands while its counter is at 2, then full re-debounce.
    bus.i_sw = 4'h8;
    for (int i = 0; i < 4; i++) step();
    chk_all("ch3_precount", 4'h0, 4'h0, 4'h0);
    i_reset = 1'b1;
    step();
    chk_all("ch3_reset", 4'h0, 4'h0, 4'h0);
    i_reset = 1'b0;
    expect_accept("ch3_redeb", 4'h0, 4'h8, 4'h8, 4'h0);

    // Reset with o_sw high clears the level without a fall pulse.
    i_reset = 1'b1;
    step();
    chk_all("reset_hi", 4'h0, 4'h0, 4'h0);
    i_reset = 1'b0;
    bus.i_sw = 4'h0;
    step();
    chk_all("reset_hi_after", 4'h0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
